mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single data `memory` instance between the instruction-fetch stage (read-only) and the load/store stage (read/write). Accepts requests with a same-cycle valid/grant handshake, registers the winning command, drives the memory for exactly one cycle, and returns registered read data to the winning requester. Data port has fixed priority; a saturating wait counter guarantees fetch forward progress. Sits between the core pipeline and `memory`, replacing the pipeline's direct memory connection.

## Interface

Parameters:
- MAX_WAIT, 4: consecutive cycles fetch may be denied while requesting before it gets priority (≥1)

Ports:
- clk  in  1  clock, all state updates on posedge
- rstn  in  1  synchronous active-low reset, sampled on posedge clk
- i_req  in  1  fetch request valid
- i_addr  in  32  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle (combinational)
- i_rvalid  out  1  fetch read data valid (one-cycle pulse)
- i_rdata  out  32  fetch read data
- d_req  in  1  load/store request valid
- d_we  in  1  1 = store, 0 = load
- d_base  in  32  load/store base register value
- d_offset  in  32  load/store signed immediate
- d_wdata  in  32  store data
- d_gnt  out  1  load/store request accepted this cycle (combinational)
- d_rvalid  out  1  load read data valid (one-cycle pulse; never asserted for stores)
- d_rdata  out  32  load read data
- m_base  out  32  to memory base
- m_offset  out  32  to memory offset
- m_r_enabled  out  1  to memory read enable
- m_w_enabled  out  1  to memory write enable
- m_w_data  out  32  to memory write data
- m_r_data  in  32  from memory combinational read data

## Operation

- Handshake: request transfers when req && gnt in the same cycle. Requester holds req and payload stable until gnt. At most one of i_gnt/d_gnt is high per cycle.
- Arbitration (combinational, every cycle): if i_req && wait_cnt == MAX_WAIT → i_gnt; else if d_req → d_gnt; else if i_req → i_gnt.
- wait_cnt: increments (saturating at MAX_WAIT) when i_req && !i_gnt; clears to 0 when i_gnt or !i_req.
- Command register (cmd): on a grant, captures src (I/D), we, base, offset, wdata; cmd_valid ← 1. Fetch captures base = i_addr, offset = 0, we = 0. No grant → cmd_valid ← 0.
- Access stage: while cmd_valid, drive m_base/m_offset/m_w_data from cmd; m_r_enabled = !we, m_w_enabled = we. While !cmd_valid both enables are 0 and address/data outputs hold last values.
- Response stage: at end of access cycle, for reads capture m_r_data into the src's rdata register and pulse that src's rvalid for one cycle. rdata holds its value until the next response to that port.
- Address arithmetic and word alignment are performed by memory; the arbiter passes base/offset unmodified, 32-bit, no truncation.
- Fully pipelined: a new grant is allowed every cycle, including while a previous command is in access or response.

## Timing

- Grant cycle N → memory access in N+1 → rvalid/rdata in N+2. Read latency 2 cycles from grant.
- Store granted in N commits to memory at the posedge ending N+1; a load granted in N+1 to the same address returns the new data (no hazard).
- Sustained throughput: one access per cycle.
- Both requesting continuously: fetch granted once every MAX_WAIT+1 cycles.
- Reset (rstn low at posedge): cmd_valid, wait_cnt, i_rvalid, d_rvalid ← 0; i_rdata, d_rdata, m_base, m_offset, m_w_data ← 0; m_r_enabled, m_w_enabled = 0 next cycle. In-flight commands are dropped: no rvalid, no memory write after the reset edge. i_gnt/d_gnt forced 0 while rstn low.

## Structure

- Package `mem_arb_pkg`: enum `src_t` {SRC_I, SRC_D}; packed struct `mem_cmd_t` {src, we, base, offset, wdata}; localparam default MAX_WAIT. The `def.sv` include provides no types for this.
- No sub-module required; the wait counter and priority logic stay inline. Top-level instantiates mem_arbiter between pipeline and memory.

## Test plan

- Fetch only: i_req, i_addr=0x10 with mem[4]=0xDEADBEEF → i_gnt same cycle, i_rvalid at N+2 with i_rdata=0xDEADBEEF, d_rvalid stays 0.
- Store then load: d_we=1, base=0x20, offset=-4, wdata=0x1234 at N; load base=0x1C, offset=0 at N+1 → mem[7]=0x1234, d_rvalid at N+3 with d_rdata=0x1234.
- Contention, MAX_WAIT=4: i_req and d_req held high 10 cycles → d_gnt cycles 0-3, i_gnt cycle 4, d_gnt 5-8, i_gnt 9; wait_cnt clears after each i_gnt.
- Back-to-back loads alternating ports every cycle → one rvalid per cycle, each routed to correct port in order, no data mixing.
- Reset mid-flight: grant store at N, rstn low at N+1 → no memory write, all outputs at reset values at N+2, no rvalid.
- Idle: no requests 5 cycles → m_r_enabled=m_w_enabled=0, both gnt and rvalid 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_pkg: shared types and defaults for the memory arbiter    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int c_MAX_WAIT_DEFAULT = 4;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  typedef struct packed {
    src_t        src;
    logic        we;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter_if: fetch, load/store and memory-side bus signals    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_base;
  logic [31:0] d_offset;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic [31:0] m_base;
  logic [31:0] m_offset;
  logic        m_r_enabled;
  logic        m_w_enabled;
  logic [31:0] m_w_data;
  logic [31:0] m_r_data;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_base, d_offset, d_wdata, m_r_data,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output m_base, m_offset, m_r_enabled, m_w_enabled, m_w_data
  );

  // Pipeline and memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_base, d_offset, d_wdata, m_r_data,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_base, m_offset, m_r_enabled, m_w_enabled, m_w_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter: fetch/load-store arbiter in front of the data memory|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = c_MAX_WAIT_DEFAULT
) (
  input  wire logic   clk,
  input  wire logic   rstn,
  mem_arbiter_if.slave bus
);

  localparam int                    c_WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0]   c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                w_fetch_starved;
  logic                w_i_gnt;
  logic                w_d_gnt;

  mem_cmd_t            r_cmd;
  logic                r_cmd_valid;
  logic                w_rd_i;
  logic                w_rd_d;

  logic                r_i_rvalid;
  logic                r_d_rvalid;
  logic [31:0]         r_i_rdata;
  logic [31:0]         r_d_rdata;

  // Data port wins unless fetch has been starved for MAX_WAIT cycles
  always_comb begin
    w_fetch_starved = bus.i_req && (r_wait_cnt == c_WAIT_MAX);
    w_i_gnt         = 1'b0;
    w_d_gnt         = 1'b0;
    if (rstn) begin
      if (w_fetch_starved) begin
        w_i_gnt = 1'b1;
      end else if (bus.d_req) begin
        w_d_gnt = 1'b1;
      end else if (bus.i_req) begin
        w_i_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wait_cnt <= '0;
    end else if (!bus.i_req || w_i_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != c_WAIT_MAX) begin
      r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
    end else begin
      r_cmd_valid <= w_i_gnt || w_d_gnt;
      if (w_i_gnt) begin
        r_cmd <= '{src: SRC_I, we: 1'b0, base: bus.i_addr,
                   offset: 32'd0, wdata: 32'd0};
      end else if (w_d_gnt) begin
        r_cmd <= '{src: SRC_D, we: bus.d_we, base: bus.d_base,
                   offset: bus.d_offset, wdata: bus.d_wdata};
      end
    end
  end

  // Enables are gated by rstn so an in-flight store never lands on the reset edge
  assign bus.m_base      = r_cmd.base;
  assign bus.m_offset    = r_cmd.offset;
  assign bus.m_w_data    = r_cmd.wdata;
  assign bus.m_r_enabled = rstn && r_cmd_valid && !r_cmd.we;
  assign bus.m_w_enabled = rstn && r_cmd_valid &&  r_cmd.we;

  assign w_rd_i = r_cmd_valid && !r_cmd.we && (r_cmd.src == SRC_I);
  assign w_rd_d = r_cmd_valid && !r_cmd.we && (r_cmd.src == SRC_D);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_i_rvalid <= w_rd_i;
      r_d_rvalid <= w_rd_d;
      if (w_rd_i) begin
        r_i_rdata <= bus.m_r_data;
      end
      if (w_rd_d) begin
        r_d_rdata <= bus.m_r_data;
      end
    end
  end

  assign bus.i_gnt    = w_i_gnt;
  assign bus.d_gnt    = w_d_gnt;
  assign bus.i_rvalid = r_i_rvalid;
  assign bus.i_rdata  = r_i_rdata;
  assign bus.d_rvalid = r_d_rvalid;
  assign bus.d_rdata  = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter: directed stimulus with a read-response scoreboard|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  exp_t q_i[$];
  exp_t q_d[$];

  logic [31:0] mem [0:255];
  logic [31:0] m_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  // Memory model: combinational read, write on posedge
  assign m_addr       = bus.m_base + bus.m_offset;
  assign bus.m_r_data = mem[m_addr[9:2]];
  always @(posedge clk) if (bus.m_w_enabled) mem[m_addr[9:2]] <= bus.m_w_data;

  function automatic logic [31:0] pat(input logic [31:0] addr);
    return 32'hC0DE_0000 | {22'd0, addr[9:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [31:0] db, input logic [31:0] doff, input logic [31:0] dwd);
    bus.i_req    = ir;
    bus.i_addr   = ia;
    bus.d_req    = dr;
    bus.d_we     = dwe;
    bus.d_base   = db;
    bus.d_offset = doff;
    bus.d_wdata  = dwd;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  // Check grants mid-cycle, queue expected read data, then move past the next posedge
  task automatic step(input string tag, input logic eig, input logic edg,
                      input logic [31:0] eidata, input logic [31:0] eddata);
    @(negedge clk);
    check({tag, " i_gnt"}, {31'd0, bus.i_gnt}, {31'd0, eig});
    check({tag, " d_gnt"}, {31'd0, bus.d_gnt}, {31'd0, edg});
    if (eig) q_i.push_back('{eidata, cyc + 2});
    if (edg && !bus.d_we) q_d.push_back('{eddata, cyc + 2});
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " m_r_enabled"}, {31'd0, bus.m_r_enabled}, 32'd0);
    check({tag, " m_w_enabled"}, {31'd0, bus.m_w_enabled}, 32'd0);
    check({tag, " m_base"},      bus.m_base,   32'd0);
    check({tag, " m_offset"},    bus.m_offset, 32'd0);
    check({tag, " m_w_data"},    bus.m_w_data, 32'd0);
    check({tag, " i_rdata"},     bus.i_rdata,  32'd0);
    check({tag, " d_rdata"},     bus.d_rdata,  32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (q_i.size() > 0 && q_i[0].due < cyc) begin
      n_vec++; n_miss++;
      $display("FAIL i_rvalid missing: got none, expected data %h at cycle %0d", q_i[0].data, q_i[0].due);
      void'(q_i.pop_front());
    end
    if (q_d.size() > 0 && q_d[0].due < cyc) begin
      n_vec++; n_miss++;
      $display("FAIL d_rvalid missing: got none, expected data %h at cycle %0d", q_d[0].data, q_d[0].due);
      void'(q_d.pop_front());
    end
    if (bus.i_rvalid) begin
      if (q_i.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL i_rvalid unexpected: got data %h, expected no response (cycle %0d)", bus.i_rdata, cyc);
      end else begin
        e = q_i.pop_front();
        check("i_rdata", bus.i_rdata, e.data);
        check("i_rvalid cycle", cyc, e.due);
      end
    end
    if (bus.d_rvalid) begin
      if (q_d.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL d_rvalid unexpected: got data %h, expected no response (cycle %0d)", bus.d_rdata, cyc);
      end else begin
        e = q_d.pop_front();
        check("d_rdata", bus.d_rdata, e.data);
        check("d_rvalid cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0]  ig_pat;
    logic [31:0] a;
    int          dn;

    for (int j = 0; j < 256; j++) mem[j] = pat(32'(j * 4));
    mem[4] = 32'hDEAD_BEEF;

    // Reset: requests present but grants must stay low
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("reset i_gnt", {31'd0, bus.i_gnt}, 32'd0);
      check("reset d_gnt", {31'd0, bus.d_gnt}, 32'd0);
    end
    @(posedge clk); #1;
    idle();
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("post-reset");
    @(posedge clk); #1;

    // Fetch only
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step("fetch", 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0);
    idle();
    repeat (3) step("fetch idle", 1'b0, 1'b0, 32'h0, 32'h0);

    // Store then dependent load
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFC, 32'h1234);
    step("store", 1'b0, 1'b1, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h1C, 32'h0, 32'h0);
    step("load", 1'b0, 1'b1, 32'h0, 32'h1234);
    idle();
    repeat (3) step("store idle", 1'b0, 1'b0, 32'h0, 32'h0);
    check("mem[7]", mem[7], 32'h1234);

    // Contention: fetch wins at cycles 4 and 9
    ig_pat = 10'b10_0001_0000;
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      a = 32'h80 + 32'(4 * dn);
      drive(1'b1, (k <= 4) ? 32'h40 : 32'h44, 1'b1, 1'b0, a, 32'h0, 32'h0);
      step("contention", ig_pat[k], !ig_pat[k], (k <= 4) ? pat(32'h40) : pat(32'h44), pat(a));
      if (!ig_pat[k]) dn++;
    end
    idle();
    repeat (3) step("contention idle", 1'b0, 1'b0, 32'h0, 32'h0);

    // Alternating ports back to back
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        drive(1'b1, 32'h200 + 32'(4 * k), 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step("alt fetch", 1'b1, 1'b0, pat(32'h200 + 32'(4 * k)), 32'h0);
      end else begin
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'(4 * k), 32'h0);
        step("alt load", 1'b0, 1'b1, 32'h0, pat(32'h300 + 32'(4 * k)));
      end
    end
    idle();
    repeat (3) step("alt idle", 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset with a store in flight
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h3F0, 32'h0, 32'hBAD0_BAD0);
    step("rst store", 1'b0, 1'b1, 32'h0, 32'h0);
    idle();
    rstn = 1'b0;
    @(negedge clk);
    check("rst m_w_enabled", {31'd0, bus.m_w_enabled}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid-flight reset");
    check("mem[252] untouched", mem[252], pat(32'h3F0));
    @(posedge clk); #1;

    // Reset with a load in flight: no response may appear
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h3F4, 32'h0, 32'h0);
    @(negedge clk);
    check("rst load d_gnt", {31'd0, bus.d_gnt}, 32'd1);
    @(posedge clk); #1;
    idle();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    // Idle
    repeat (5) begin
      @(negedge clk);
      check("idle m_r_enabled", {31'd0, bus.m_r_enabled}, 32'd0);
      check("idle m_w_enabled", {31'd0, bus.m_w_enabled}, 32'd0);
      check("idle i_gnt", {31'd0, bus.i_gnt}, 32'd0);
      check("idle d_gnt", {31'd0, bus.d_gnt}, 32'd0);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("i responses outstanding", q_i.size(), 32'd0);
    check("d responses outstanding", q_d.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
